// File: rtl/mc51_mem_ctrl.sv
// 8051-core memory controller: turns psen/rd/we strobes into a registered request/ack backend cycle.
// Optional one-entry code-fetch buffer enabled by defining MC51_FETCH_CACHE_EN.
module mc51_mem_ctrl #(
    parameter logic [3:0] WAIT_CYC = 4'd0,
    parameter logic [7:0] TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_psen_n,
    input  logic        mem_rd_n,
    input  logic        mem_we_n,
    input  logic [15:0] mem_addr,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        mem_data_rdy,
    output logic        ram_req,
    output logic        ram_we,
    output logic        ram_code,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic        ram_ack,
    input  logic [7:0]  ram_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state_reg, state_next;
    logic [15:0] ram_addr_reg;
    logic [7:0]  ram_wdata_reg;
    logic        ram_we_reg;
    logic        ram_code_reg;
    logic        read_reg;
    logic [7:0]  rdata_reg;
    logic [7:0]  mem_rdata_reg;
    logic        bus_err_reg;
    logic [3:0]  wait_cnt_reg;
    logic [7:0]  tmo_cnt_reg;

    // Priority psen > rd > we: only the winning strobe defines the access type.
    logic start, sel_code, sel_read, sel_write;
    assign start     = ~(mem_psen_n & mem_rd_n & mem_we_n);
    assign sel_code  = ~mem_psen_n;
    assign sel_read  = ~mem_psen_n | ~mem_rd_n;
    assign sel_write = mem_psen_n & mem_rd_n & ~mem_we_n;

    logic ack_hit, tmo_hit, wait_done;
    assign ack_hit   = (state_reg == S_REQ) && ram_ack;
    assign tmo_hit   = (state_reg == S_REQ) && !ram_ack && (tmo_cnt_reg == TIMEOUT - 8'd1);
    assign wait_done = (wait_cnt_reg == WAIT_CYC - 4'd1);

    logic       cache_hit;
    logic [7:0] cache_rdata;

`ifdef MC51_FETCH_CACHE_EN
    logic [15:0] cache_tag_reg;
    logic [7:0]  cache_data_reg;
    logic        cache_valid_reg;

    assign cache_hit   = ~mem_psen_n & cache_valid_reg & (cache_tag_reg == mem_addr);
    assign cache_rdata = cache_data_reg;

    // Only acknowledged fetches refill the buffer; timeouts and data writes leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_tag_reg   <= 16'h0000;
            cache_data_reg  <= 8'h00;
            cache_valid_reg <= 1'b0;
        end else if (ack_hit && ram_code_reg) begin
            cache_tag_reg   <= ram_addr_reg;
            cache_data_reg  <= ram_rdata;
            cache_valid_reg <= 1'b1;
        end
    end
`else
    assign cache_hit   = 1'b0;
    assign cache_rdata = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = cache_hit ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (ack_hit) begin
                    state_next = (WAIT_CYC != 4'd0) ? S_WAIT : S_DONE;
                end else if (tmo_hit) begin
                    state_next = S_DONE;
                end
            end
            S_WAIT: begin
                if (wait_done) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_data_rdy = (state_reg == S_IDLE);
        ram_req      = (state_reg == S_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr_reg  <= 16'h0000;
            ram_wdata_reg <= 8'h00;
            ram_we_reg    <= 1'b0;
            ram_code_reg  <= 1'b0;
            read_reg      <= 1'b0;
            rdata_reg     <= 8'h00;
            mem_rdata_reg <= 8'h00;
            bus_err_reg   <= 1'b0;
            wait_cnt_reg  <= 4'd0;
            tmo_cnt_reg   <= 8'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        ram_addr_reg  <= mem_addr;
                        ram_wdata_reg <= mem_wdata;
                        ram_we_reg    <= sel_write;
                        ram_code_reg  <= sel_code;
                        read_reg      <= sel_read;
                        wait_cnt_reg  <= 4'd0;
                        tmo_cnt_reg   <= 8'd0;
                        if (cache_hit) begin
                            rdata_reg <= cache_rdata;
                        end
                    end
                end
                S_REQ: begin
                    tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                    if (ack_hit) begin
                        if (read_reg) begin
                            rdata_reg <= ram_rdata;
                        end
                    end else if (tmo_hit) begin
                        bus_err_reg <= 1'b1;
                        if (read_reg) begin
                            rdata_reg <= 8'hFF;
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg + 4'd1;
                end
                S_DONE: begin
                    if (read_reg) begin
                        mem_rdata_reg <= rdata_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_rdata = mem_rdata_reg;
    assign ram_we    = ram_we_reg;
    assign ram_code  = ram_code_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;
    assign bus_err   = bus_err_reg;

endmodule

// File: tb/tb_mc51_mem_ctrl.sv
// Testbench for mc51_mem_ctrl: table of accesses with a scoreboard, plus hand-written corner sequences.
// Cache expectations follow MC51_FETCH_CACHE_EN when the bench is built with it.
module tb_mc51_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psen_n = 1'b1, rd_n = 1'b1, we_n = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        ack0 = 1'b0, ack1 = 1'b0;
    logic [7:0]  rdata0 = 8'h00, rdata1 = 8'h00;

    logic [7:0]  mrd0, mrd1, rwd0, rwd1;
    logic        rdy0, rdy1, req0, req1, we0, we1, code0, code1, err0, err1;
    logic [15:0] radr0, radr1;

    always #5 clk = ~clk;

    mc51_mem_ctrl #(.WAIT_CYC(4'd0), .TIMEOUT(8'd8)) dut0 (
        .clk(clk), .rst(rst), .mem_psen_n(psen_n), .mem_rd_n(rd_n), .mem_we_n(we_n),
        .mem_addr(addr), .mem_wdata(wdata), .mem_rdata(mrd0), .mem_data_rdy(rdy0),
        .ram_req(req0), .ram_we(we0), .ram_code(code0), .ram_addr(radr0), .ram_wdata(rwd0),
        .ram_ack(ack0), .ram_rdata(rdata0), .bus_err(err0)
    );

    mc51_mem_ctrl #(.WAIT_CYC(4'd3), .TIMEOUT(8'd255)) dut1 (
        .clk(clk), .rst(rst), .mem_psen_n(psen_n), .mem_rd_n(rd_n), .mem_we_n(we_n),
        .mem_addr(addr), .mem_wdata(wdata), .mem_rdata(mrd1), .mem_data_rdy(rdy1),
        .ram_req(req1), .ram_we(we1), .ram_code(code1), .ram_addr(radr1), .ram_wdata(rwd1),
        .ram_ack(ack1), .ram_rdata(rdata1), .bus_err(err1)
    );

    typedef struct {
        logic        psen_n, rd_n, we_n;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          ack_dly;   // REQ cycles without ack before ack; -1 = never
        logic        exp_req, exp_code, exp_we;
        int          exp_lat;   // cycles with mem_data_rdy low
        logic [7:0]  exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t sb_q[$];
    vec_t vecs[9];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_txn = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; psen_n = 1'b1; rd_n = 1'b1; we_n = 1'b1; ack0 = 1'b0; ack1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_access(input bit sel, input vec_t v);
        vec_t e;
        int   lat, reqc;
        bit   saw_req;
        @(negedge clk);
        psen_n = v.psen_n; rd_n = v.rd_n; we_n = v.we_n; addr = v.addr; wdata = v.wdata;
        sb_q.push_back(v);
        lat = 0; reqc = 0; saw_req = 1'b0;
        @(negedge clk);
        psen_n = 1'b1; rd_n = 1'b1; we_n = 1'b1;
        while (!(sel ? rdy1 : rdy0) && lat < 300) begin
            lat++;
            ack0 = 1'b0; ack1 = 1'b0;
            if (sel ? req1 : req0) begin
                if (!saw_req) begin
                    check("ram_code", 32'(sel ? code1 : code0), 32'(sb_q[0].exp_code));
                    check("ram_we", 32'(sel ? we1 : we0), 32'(sb_q[0].exp_we));
                    check("ram_addr", 32'(sel ? radr1 : radr0), 32'(sb_q[0].addr));
                    check("ram_wdata", 32'(sel ? rwd1 : rwd0), 32'(sb_q[0].wdata));
                end
                saw_req = 1'b1;
                if (reqc == v.ack_dly) begin
                    if (sel) begin ack1 = 1'b1; rdata1 = v.rdata; end
                    else     begin ack0 = 1'b1; rdata0 = v.rdata; end
                end
                reqc++;
            end
            @(negedge clk);
        end
        ack0 = 1'b0; ack1 = 1'b0;
        e = sb_q.pop_front();
        check("latency", 32'(lat), 32'(e.exp_lat));
        check("req_seen", 32'(saw_req), 32'(e.exp_req));
        check("mem_rdata", 32'(sel ? mrd1 : mrd0), 32'(e.exp_rdata));
        check("bus_err", 32'(sel ? err1 : err0), 32'(e.exp_err));
        $display("txn %0d dut%0d addr=%04h lat=%0d req=%0d rdata=%02h err=%0d",
                 n_txn, sel, v.addr, lat, saw_req, sel ? mrd1 : mrd0, sel ? err1 : err0);
        n_txn++;
    endtask

    vec_t c0, c1, c2, c3, w0;
    int   cnt;

    initial begin
        //           psen rd   we    addr     wdata  rdata  dly req code we  lat rdata  err
        vecs[0] = '{1'b0,1'b1,1'b1,16'h0002,8'h00,8'h74, 0,1'b1,1'b1,1'b0,2,8'h74,1'b0};
        vecs[1] = '{1'b1,1'b0,1'b1,16'h0030,8'h00,8'hA5, 2,1'b1,1'b0,1'b0,4,8'hA5,1'b0};
        vecs[2] = '{1'b1,1'b1,1'b0,16'h00F0,8'h12,8'h00, 0,1'b1,1'b0,1'b1,2,8'hA5,1'b0};
        vecs[3] = '{1'b0,1'b0,1'b1,16'h1234,8'h00,8'h3C, 1,1'b1,1'b1,1'b0,3,8'h3C,1'b0};
        vecs[4] = '{1'b1,1'b0,1'b0,16'h0040,8'h99,8'h5A, 0,1'b1,1'b0,1'b0,2,8'h5A,1'b0};
        vecs[5] = '{1'b1,1'b1,1'b0,16'hFFFF,8'hEE,8'h00, 3,1'b1,1'b0,1'b1,5,8'h5A,1'b0};
        vecs[6] = '{1'b1,1'b0,1'b1,16'h0050,8'h00,8'h00,-1,1'b1,1'b0,1'b0,9,8'hFF,1'b1};
        vecs[7] = '{1'b1,1'b0,1'b1,16'h0060,8'h00,8'h11, 0,1'b1,1'b0,1'b0,2,8'h11,1'b1};
        vecs[8] = '{1'b1,1'b1,1'b0,16'h0070,8'h44,8'h00,-1,1'b1,1'b0,1'b1,9,8'h11,1'b1};

        do_reset();
        @(negedge clk);
        check("rst_rdy", 32'(rdy0), 32'd1);
        check("rst_mem_rdata", 32'(mrd0), 32'h00);
        check("rst_ram_req", 32'(req0), 32'd0);
        check("rst_ram_we", 32'(we0), 32'd0);
        check("rst_ram_code", 32'(code0), 32'd0);
        check("rst_ram_addr", 32'(radr0), 32'h0000);
        check("rst_ram_wdata", 32'(rwd0), 32'h00);
        check("rst_bus_err", 32'(err0), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_access(1'b0, vecs[i]);
        end

        // Wait states: 6 REQ cycles (ack on the 6th), 3 WAIT, 1 DONE.
        do_reset();
        w0 = '{1'b1,1'b0,1'b1,16'h0030,8'h00,8'hA5,5,1'b1,1'b0,1'b0,10,8'hA5,1'b0};
        run_access(1'b1, w0);

        // A strobe held low past completion starts a second access.
        do_reset();
        @(negedge clk);
        rd_n = 1'b0; addr = 16'h0070;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ack0 = req0;
            rdata0 = (cnt == 0) ? 8'h21 : 8'h22;
            if (req0) cnt++;
        end
        rd_n = 1'b1; ack0 = 1'b0;
        check("held_strobe_reqs", 32'(cnt), 32'd2);
        check("held_strobe_rdata", 32'(mrd0), 32'h22);
        $display("txn %0d held rd strobe: requests=%0d rdata=%02h", n_txn, cnt, mrd0);
        n_txn++;
        @(negedge clk);

        // Fetch buffer: repeat fetch of 0x0004 around a data write to the same address.
        c0 = '{1'b0,1'b1,1'b1,16'h0004,8'h00,8'h5E,0,1'b1,1'b1,1'b0,2,8'h5E,1'b0};
        c1 = '{1'b1,1'b1,1'b0,16'h0004,8'h33,8'h00,0,1'b1,1'b0,1'b1,2,8'h5E,1'b0};
`ifdef MC51_FETCH_CACHE_EN
        c2 = '{1'b0,1'b1,1'b1,16'h0004,8'h00,8'hC3,0,1'b0,1'b1,1'b0,1,8'h5E,1'b0};
`else
        c2 = '{1'b0,1'b1,1'b1,16'h0004,8'h00,8'h5E,0,1'b1,1'b1,1'b0,2,8'h5E,1'b0};
`endif
        run_access(1'b0, c0);
        run_access(1'b0, c1);
        run_access(1'b0, c2);

        // Reset in the middle of REQ aborts the access on the next cycle.
        @(negedge clk);
        psen_n = 1'b0; addr = 16'h0100;
        @(negedge clk);
        psen_n = 1'b1;
        check("mid_req_active", 32'(req0), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ram_req", 32'(req0), 32'd0);
        check("mid_rst_rdy", 32'(rdy0), 32'd1);
        $display("txn %0d reset mid-REQ: ram_req=%0d rdy=%0d", n_txn, req0, rdy0);
        n_txn++;
        rst = 1'b0;

        // After reset the buffer is invalid, so the same fetch goes to the backend again.
        c3 = '{1'b0,1'b1,1'b1,16'h0004,8'h00,8'h77,0,1'b1,1'b1,1'b0,2,8'h77,1'b0};
        run_access(1'b0, c3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
